// File: rtl/secuenciador_rtc.sv
// Command sequencer for the RTC read/write engine: power-up init writes, periodic
// six-register time refresh into a shadow bank, and single user writes in between.
module secuenciador_rtc #(
    parameter int unsigned TIMEOUT_CICLOS = 200,
    parameter logic [7:0]  ADDR_CTRL      = 8'h02,
    parameter logic [7:0]  ADDR_TRANSFER  = 8'hF0,
    parameter logic [7:0]  ADDR_BASE_HORA = 8'h21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_lectura,
    input  logic       req_escribir,
    input  logic [7:0] addr_usuario,
    input  logic [7:0] dato_usuario,
    input  logic [7:0] dato_leido,
    input  logic       fin_lectura_escritura,
    output logic [7:0] addr_RAM,
    output logic [7:0] dato_escribir,
    output logic       escribir_leer,
    output logic       en_funcion,
    output logic       ocupado,
    output logic       ack_escritura,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic       datos_listos,
    output logic       error_rtc
);

    typedef enum logic [2:0] {
        S_INIT1, S_INIT2, S_IDLE, S_USR_WR, S_TRANSFER, S_READ, S_COMMIT
    } estado_t;

    // F_PREP is a dead cycle before the first ISSUE after reset so that the
    // registered engine outputs can be loaded before en_funcion rises.
    typedef enum logic [1:0] {F_PREP, F_ISSUE, F_WAIT} fase_t;

    estado_t    estado, estado_sig;
    fase_t      fase, fase_sig;
    logic [2:0] indice, indice_sig;
    logic [7:0] contador;
    logic       pendiente_lectura;
    logic [7:0] temp [6];
    logic       fin_ok, vencido;

    assign ocupado = (estado != S_IDLE);
    assign fin_ok  = (fase == F_WAIT) && fin_lectura_escritura;
    assign vencido = (fase == F_WAIT) && !fin_lectura_escritura
                     && (contador == 8'(TIMEOUT_CICLOS));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        estado_sig = estado;
        fase_sig   = fase;
        indice_sig = indice;
        case (estado)
            S_IDLE: begin
                if (req_escribir) begin
                    estado_sig = S_USR_WR;
                    fase_sig   = F_ISSUE;
                end else if (tick_lectura || pendiente_lectura) begin
                    estado_sig = S_TRANSFER;
                    fase_sig   = F_ISSUE;
                end
            end
            S_COMMIT: begin
                estado_sig = S_IDLE;
                fase_sig   = F_PREP;
            end
            default: begin
                case (fase)
                    F_PREP:  fase_sig = F_ISSUE;
                    F_ISSUE: fase_sig = F_WAIT;
                    default: begin
                        if (fin_ok) begin
                            fase_sig = F_ISSUE;
                            case (estado)
                                S_INIT1:    estado_sig = S_INIT2;
                                S_TRANSFER: begin
                                    estado_sig = S_READ;
                                    indice_sig = 3'd0;
                                end
                                S_READ: begin
                                    if (indice == 3'd5) begin
                                        estado_sig = S_COMMIT;
                                        fase_sig   = F_PREP;
                                    end else begin
                                        indice_sig = indice + 3'd1;
                                    end
                                end
                                default: begin
                                    estado_sig = S_IDLE;
                                    fase_sig   = F_PREP;
                                end
                            endcase
                        end else if (vencido) begin
                            estado_sig = S_IDLE;
                            fase_sig   = F_PREP;
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado            <= S_INIT1;
            fase              <= F_PREP;
            indice            <= 3'd0;
            contador          <= 8'd0;
            pendiente_lectura <= 1'b0;
            addr_RAM          <= 8'h00;
            dato_escribir     <= 8'h00;
            escribir_leer     <= 1'b0;
            en_funcion        <= 1'b0;
            ack_escritura     <= 1'b0;
            datos_listos      <= 1'b0;
            error_rtc         <= 1'b0;
            {seg, min, hora, dia, mes, anio} <= '0;
        end else begin
            estado        <= estado_sig;
            fase          <= fase_sig;
            indice        <= indice_sig;
            en_funcion    <= (fase_sig == F_ISSUE);
            ack_escritura <= (estado == S_USR_WR) && fin_ok;
            datos_listos  <= (estado == S_COMMIT);

            if (fase_sig == F_ISSUE)     contador <= 8'd0;
            else if (fase != F_PREP)     contador <= contador + 8'd1;

            // A tick in the same cycle as a write request must survive the write.
            if (estado == S_IDLE && estado_sig == S_TRANSFER) pendiente_lectura <= 1'b0;
            else if (tick_lectura)                            pendiente_lectura <= 1'b1;

            if (fase_sig == F_ISSUE) begin
                case (estado_sig)
                    S_INIT1:    {addr_RAM, dato_escribir, escribir_leer} <= {ADDR_CTRL, 8'h10, 1'b1};
                    S_INIT2:    {addr_RAM, dato_escribir, escribir_leer} <= {ADDR_CTRL, 8'h00, 1'b1};
                    S_USR_WR:   {addr_RAM, dato_escribir, escribir_leer} <= {addr_usuario, dato_usuario, 1'b1};
                    S_TRANSFER: {addr_RAM, dato_escribir, escribir_leer} <= {ADDR_TRANSFER, 8'hF0, 1'b1};
                    S_READ:     {addr_RAM, dato_escribir, escribir_leer} <=
                                    {ADDR_BASE_HORA + {5'd0, indice_sig}, 8'h00, 1'b0};
                    default: ;
                endcase
            end

            if (vencido)                 error_rtc <= 1'b1;
            else if (estado == S_COMMIT) error_rtc <= 1'b0;

            if (estado == S_COMMIT)
                {seg, min, hora, dia, mes, anio} <= {temp[0], temp[1], temp[2], temp[3], temp[4], temp[5]};
        end
    end

    // NOTE: the temp bank has no reset; it is only copied after all six bytes are rewritten.
    always_ff @(posedge clk) begin
        if (estado == S_READ && fin_ok) temp[indice] <= dato_leido;
    end

endmodule

// File: tb/tb_secuenciador_rtc.sv
// Randomised bench for secuenciador_rtc: behavioural engine stub, transaction
// scoreboard built from the command-sequence rules, shadow and pulse counters.
module tb_secuenciador_rtc;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_lectura, req_escribir;
    logic [7:0] addr_usuario, dato_usuario, dato_leido;
    logic       fin_lectura_escritura;
    logic [7:0] addr_RAM, dato_escribir;
    logic       escribir_leer, en_funcion, ocupado, ack_escritura;
    logic [7:0] seg, min, hora, dia, mes, anio;
    logic       datos_listos, error_rtc;

    secuenciador_rtc #(.TIMEOUT_CICLOS(T)) dut (
        .clk(clk), .reset(reset),
        .tick_lectura(tick_lectura), .req_escribir(req_escribir),
        .addr_usuario(addr_usuario), .dato_usuario(dato_usuario),
        .dato_leido(dato_leido), .fin_lectura_escritura(fin_lectura_escritura),
        .addr_RAM(addr_RAM), .dato_escribir(dato_escribir),
        .escribir_leer(escribir_leer), .en_funcion(en_funcion),
        .ocupado(ocupado), .ack_escritura(ack_escritura),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
        .datos_listos(datos_listos), .error_rtc(error_rtc)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic dir; logic [7:0] addr; logic [7:0] dato; } trans_t;

    trans_t      obs_q[$], exp_q[$];
    int          obs_cyc[$];
    int          n_checks = 0, n_errors = 0;
    int          cyc = 0;
    int          latencia = 10, cuenta = 0, sil_issue_cyc = 0;
    logic        silencio = 1'b0;
    logic [7:0]  silencio_addr = 8'h00, addr_eng = 8'h00;
    logic [7:0]  rtc [6];
    logic [47:0] sh_exp = '0;
    int          ack_cnt = 0, dl_cnt = 0, ack_cyc = 0, err_cyc = 0;
    logic        prev_en = 1'b0, prev_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] sombra();
        return {seg, min, hora, dia, mes, anio};
    endfunction

    // Engine stub: answers fin 'latencia' cycles after en_funcion, except for a silenced address.
    initial begin
        fin_lectura_escritura = 1'b0;
        dato_leido = 8'h00;
        forever begin
            @(negedge clk);
            fin_lectura_escritura = 1'b0;
            if (reset) begin
                cuenta = 0;
            end else begin
                if (cuenta > 0) begin
                    cuenta--;
                    if (cuenta == 0) begin
                        int idx;
                        idx = int'(addr_eng) - 'h21;
                        fin_lectura_escritura = 1'b1;
                        dato_leido = (idx >= 0 && idx < 6) ? rtc[idx] : 8'hEE;
                        check("addr_estable", addr_RAM, addr_eng);
                    end
                end
                if (en_funcion) begin
                    addr_eng = addr_RAM;
                    if (silencio && addr_RAM == silencio_addr) sil_issue_cyc = cyc;
                    else cuenta = latencia;
                end
            end
        end
    end

    // Monitor: logs issued transactions and counts output pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (en_funcion) begin
                    check("en_un_ciclo", prev_en, 1'b0);
                    obs_q.push_back(trans_t'{escribir_leer, addr_RAM, dato_escribir});
                    obs_cyc.push_back(cyc);
                end
                if (ack_escritura) begin
                    ack_cnt++;
                    ack_cyc = cyc;
                end
                if (datos_listos) begin
                    dl_cnt++;
                    check("sombra_en_listos", sombra(), sh_exp);
                end
                if (error_rtc && !prev_err) err_cyc = cyc;
            end
            prev_en  = en_funcion && !reset;
            prev_err = error_rtc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    task automatic exp_escritura(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back(trans_t'{1'b1, a, d});
    endtask

    task automatic exp_init();
        exp_escritura(8'h02, 8'h10);
        exp_escritura(8'h02, 8'h00);
    endtask

    task automatic exp_refresco();
        exp_escritura(8'hF0, 8'hF0);
        for (int k = 0; k < 6; k++) exp_q.push_back(trans_t'{1'b0, 8'h21 + 8'(k), 8'h00});
    endtask

    task automatic comparar_trans(input string tag);
        check({tag, "_num"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            trans_t o;
            o = obs_q[i];
            if (!exp_q[i].dir) o.dato = 8'h00;
            check($sformatf("%s_t%0d", tag, i), o, exp_q[i]);
        end
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic esperar_quieto(input string tag);
        int quietos = 0;
        int n = 0;
        while (quietos < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!ocupado && cuenta == 0) quietos++;
            else quietos = 0;
        end
        check({tag, "_termina"}, quietos >= 3, 1'b1);
    endtask

    task automatic pulso(input logic t, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tick_lectura = t;
        req_escribir = w;
        addr_usuario = a;
        dato_usuario = d;
        @(negedge clk);
        tick_lectura = 1'b0;
        req_escribir = 1'b0;
    endtask

    task automatic nuevo_rtc();
        for (int k = 0; k < 6; k++) rtc[k] = 8'($urandom);
        sh_exp = {rtc[0], rtc[1], rtc[2], rtc[3], rtc[4], rtc[5]};
    endtask

    initial begin
        logic [7:0] a, d;
        int op;
        reset = 1'b1;
        tick_lectura = 1'b0;
        req_escribir = 1'b0;
        addr_usuario = 8'h00;
        dato_usuario = 8'h00;
        for (int k = 0; k < 6; k++) rtc[k] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_ocupado", ocupado, 1'b1);
        check("rst_en", en_funcion, 1'b0);
        check("rst_addr", addr_RAM, 8'h00);
        check("rst_dato", dato_escribir, 8'h00);
        check("rst_dir", escribir_leer, 1'b0);
        check("rst_ack", ack_escritura, 1'b0);
        check("rst_listos", datos_listos, 1'b0);
        check("rst_error", error_rtc, 1'b0);
        check("rst_sombra", sombra(), 48'h0);

        reset = 1'b0;
        esperar_quieto("init");
        exp_init();
        comparar_trans("init");
        check("init_ocupado", ocupado, 1'b0);

        // Directed refresh with known time bytes.
        rtc = '{8'h45, 8'h30, 8'h12, 8'h17, 8'h05, 8'h16};
        sh_exp = 48'h45_30_12_17_05_16;
        dl_cnt = 0;
        pulso(1'b1, 1'b0, 8'h00, 8'h00);
        esperar_quieto("ref1");
        exp_refresco();
        comparar_trans("ref1");
        check("ref1_listos", dl_cnt, 1);
        check("ref1_sombra", sombra(), sh_exp);

        // Write and tick in the same cycle: write first, then refresh after one idle cycle.
        latencia = 4;
        nuevo_rtc();
        ack_cnt = 0;
        dl_cnt = 0;
        pulso(1'b1, 1'b1, 8'h22, 8'h59);
        esperar_quieto("mixto");
        if (obs_cyc.size() >= 2) begin
            check("mixto_lat_ack", ack_cyc - obs_cyc[0], 1 + latencia);
            check("mixto_hueco", obs_cyc[1] - ack_cyc, 1);
        end
        exp_escritura(8'h22, 8'h59);
        exp_refresco();
        comparar_trans("mixto");
        check("mixto_ack", ack_cnt, 1);
        check("mixto_listos", dl_cnt, 1);
        check("mixto_sombra", sombra(), sh_exp);

        // Random operations.
        for (int it = 0; it < 25; it++) begin
            latencia = $urandom_range(1, 15);
            op = $urandom_range(0, 4);
            a = 8'($urandom);
            d = 8'($urandom);
            ack_cnt = 0;
            dl_cnt = 0;
            case (op)
                0: begin
                    pulso(1'b0, 1'b1, a, d);
                    exp_escritura(a, d);
                end
                1: begin
                    nuevo_rtc();
                    pulso(1'b1, 1'b0, 8'h00, 8'h00);
                    exp_refresco();
                end
                2: begin
                    nuevo_rtc();
                    pulso(1'b1, 1'b1, a, d);
                    exp_escritura(a, d);
                    exp_refresco();
                end
                3: begin
                    nuevo_rtc();
                    pulso(1'b1, 1'b0, 8'h00, 8'h00);
                    repeat (2) @(negedge clk);
                    for (int j = 0; j < 3; j++) pulso(1'b1, 1'b0, 8'h00, 8'h00);
                    exp_refresco();
                    exp_refresco();
                end
                default: begin
                    nuevo_rtc();
                    pulso(1'b1, 1'b0, 8'h00, 8'h00);
                    repeat (3) @(negedge clk);
                    pulso(1'b0, 1'b1, a, d);
                    exp_refresco();
                end
            endcase
            esperar_quieto($sformatf("rnd%0d", it));
            comparar_trans($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_ack", it), ack_cnt, (op == 0 || op == 2) ? 1 : 0);
            check($sformatf("rnd%0d_listos", it), dl_cnt, (op == 0) ? 0 : (op == 3) ? 2 : 1);
            check($sformatf("rnd%0d_sombra", it), sombra(), sh_exp);
            check($sformatf("rnd%0d_error", it), error_rtc, 1'b0);
        end

        // Engine stops answering on READ_2: abandon, keep shadows, flag error.
        latencia = 5;
        silencio = 1'b1;
        silencio_addr = 8'h23;
        for (int k = 0; k < 6; k++) rtc[k] = 8'($urandom);
        dl_cnt = 0;
        err_cyc = -1000;
        pulso(1'b1, 1'b0, 8'h00, 8'h00);
        esperar_quieto("to_lect");
        check("to_lect_error", error_rtc, 1'b1);
        check("to_lect_tiempo", (err_cyc - sil_issue_cyc) inside {T, T + 1}, 1'b1);
        check("to_lect_sombra", sombra(), sh_exp);
        check("to_lect_listos", dl_cnt, 0);
        check("to_lect_ocupado", ocupado, 1'b0);
        exp_escritura(8'hF0, 8'hF0);
        for (int k = 0; k < 3; k++) exp_q.push_back(trans_t'{1'b0, 8'h21 + 8'(k), 8'h00});
        comparar_trans("to_lect");

        // Timeout on a user write: no ack.
        silencio_addr = 8'h40;
        ack_cnt = 0;
        pulso(1'b0, 1'b1, 8'h40, 8'hAA);
        esperar_quieto("to_wr");
        check("to_wr_ack", ack_cnt, 0);
        check("to_wr_error", error_rtc, 1'b1);
        exp_escritura(8'h40, 8'hAA);
        comparar_trans("to_wr");

        // A successful refresh clears the sticky error.
        silencio = 1'b0;
        nuevo_rtc();
        dl_cnt = 0;
        pulso(1'b1, 1'b0, 8'h00, 8'h00);
        esperar_quieto("recupera");
        exp_refresco();
        comparar_trans("recupera");
        check("recupera_error", error_rtc, 1'b0);
        check("recupera_listos", dl_cnt, 1);
        check("recupera_sombra", sombra(), sh_exp);

        // Reset in the middle of a user write wait.
        latencia = 10;
        ack_cnt = 0;
        pulso(1'b0, 1'b1, 8'h33, 8'h77);
        repeat (3) @(negedge clk);
        exp_escritura(8'h33, 8'h77);
        comparar_trans("rst_wr");
        #1 reset = 1'b1;
        #1;
        check("rstm_en", en_funcion, 1'b0);
        check("rstm_addr", addr_RAM, 8'h00);
        check("rstm_dato", dato_escribir, 8'h00);
        check("rstm_dir", escribir_leer, 1'b0);
        check("rstm_ocupado", ocupado, 1'b1);
        check("rstm_error", error_rtc, 1'b0);
        check("rstm_sombra", sombra(), 48'h0);
        sh_exp = '0;
        repeat (15) @(negedge clk);
        reset = 1'b0;
        esperar_quieto("reinit");
        exp_init();
        comparar_trans("reinit");
        check("reinit_ack", ack_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_rtc.md
Name: secuenciador_rtc

Overview:
- Command sequencer directly upstream of the RTC read/write engine (multiplexed A/D bus driver plus control-signal generator).
- After reset, runs a fixed RTC initialisation write sequence. On each tick, issues a time-transfer command and reads six time registers into a shadow bank. Between reads, it services single-register user writes.
- Drives the engine's address, data, direction and start inputs. Consumes the engine's done pulse and read data.

Parameters:
- TIMEOUT_CICLOS, 200: maximum cycles to wait for fin_lectura_escritura per transaction, range 1..255.
- ADDR_CTRL, 8'h02: RTC control/status register address used by init.
- ADDR_TRANSFER, 8'hF0: command address that latches time into RTC RAM.
- ADDR_BASE_HORA, 8'h21: address of the seconds register. The five following addresses are min, hora, dia, mes, anio.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- tick_lectura  in  1  one-cycle request to refresh time
- req_escribir  in  1  one-cycle user write request, sampled only when ocupado=0
- addr_usuario  in  8  user write address, captured with req_escribir
- dato_usuario  in  8  user write data, captured with req_escribir
- dato_leido  in  8  engine read data, valid in the fin_lectura_escritura cycle
- fin_lectura_escritura  in  1  engine one-cycle done pulse
- addr_RAM  out  8  engine address
- dato_escribir  out  8  engine write data
- escribir_leer  out  1  engine direction: 1=write, 0=read
- en_funcion  out  1  one-cycle engine start pulse
- ocupado  out  1  high whenever state is not IDLE
- ack_escritura  out  1  one-cycle pulse when a user write completes
- seg, min, hora, dia, mes, anio  out  8 each  BCD shadow registers, raw RTC bytes
- datos_listos  out  1  one-cycle pulse when the shadow bank updates
- error_rtc  out  1  set on timeout

Behaviour:
- Reset values:
  - addr_RAM, dato_escribir, escribir_leer, en_funcion = 0.
  - ack_escritura, datos_listos, error_rtc = 0.
  - All shadow registers = 8'h00.
  - ocupado = 1, because the state resets to INIT1.
- Transaction primitive: every access is an ISSUE/WAIT pair.
  - ISSUE lasts 1 cycle. It loads addr_RAM, dato_escribir and escribir_leer, and pulses en_funcion=1. The timeout counter clears.
  - WAIT holds addr_RAM, dato_escribir and escribir_leer stable. It increments the counter each cycle.
  - WAIT exits on fin_lectura_escritura=1. For reads, dato_leido is captured in that same cycle.
  - WAIT aborts when the counter reaches TIMEOUT_CICLOS with no fin.
  - fin pulses outside WAIT are ignored.
- State sequence:
  - INIT1: write 8'h10 to ADDR_CTRL.
  - INIT2: write 8'h00 to ADDR_CTRL.
  - IDLE: wait for a request.
  - USR_WR: write captured addr/data, then pulse ack_escritura, then go to IDLE.
  - TRANSFER: write 8'hF0 to ADDR_TRANSFER.
  - READ_k, k=0..5: read ADDR_BASE_HORA+k into temp[k].
  - COMMIT: copy temp to seg..anio in a single cycle, pulse datos_listos, clear error_rtc, go to IDLE.
- IDLE arbitration:
  - A pending write has priority over a pending read.
  - If tick_lectura and req_escribir arrive in the same cycle, the write is served first, then the read sequence starts immediately after.
- Pending flags:
  - tick_lectura arriving while ocupado=1 sets a one-deep pending_lectura flag. Extra ticks merge into it. The flag is cleared when TRANSFER issues.
  - req_escribir while ocupado=1 is ignored with no ack. The caller retries.
- Timeout: sets error_rtc (sticky), abandons the remaining sequence and goes to IDLE.
  - During READ_k, the shadow registers stay unchanged and there is no datos_listos.
  - During USR_WR, no ack_escritura is given.
  - During INIT, the init sequence is not retried. The block proceeds to IDLE.
- Shadow bank: the six outputs change only in COMMIT, so they never show a mix of old and new bytes.
- Reset mid-operation: all registers return to reset values immediately. en_funcion drops and the sequence restarts at INIT1 after release.
- Latency, with an engine responding N cycles after en_funcion:
  - User write: 1+N cycles from ISSUE to ack, plus 1 cycle IDLE decode.
  - Full refresh: 7 transactions plus COMMIT.

Test Plan:
- Release reset with the engine model answering fin after 10 cycles -> exactly two writes (02<-10, then 02<-00), then ocupado=0. en_funcion is one cycle wide each time, and escribir_leer=1.
- tick_lectura with the model returning 8'h45, 8'h30, 8'h12, 8'h17, 8'h05, 8'h16 -> a write to F0, then reads of 21..26 with escribir_leer=0. Then seg=45, min=30, hora=12, dia=17, mes=05, anio=16 together with a single datos_listos pulse.
- req_escribir (addr 8'h22, data 8'h59) and tick_lectura in the same cycle -> write 22<-59 and ack_escritura first, then the refresh sequence with no idle gap beyond 1 cycle.
- Model stops answering during READ_2 with TIMEOUT_CICLOS=20 -> error_rtc=1 twenty cycles after ISSUE, shadow values unchanged, ocupado=0. The next successful refresh clears error_rtc.
- Three tick_lectura pulses during one refresh -> exactly one additional refresh follows.
- Assert reset in the middle of USR_WR WAIT -> outputs reset asynchronously, no ack_escritura, and INIT1 reissues after release.
